// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_STATE_FAULT is only reachable with INSTRUCTION_FETCH_MISALIGN_TRAP_EN.
package instruction_fetch_pkg;

    localparam int unsigned INSTRUCTION_BYTES = 4;
    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH_STATE_BOOT  = 3'd0,
        FETCH_STATE_REQ   = 3'd1,
        FETCH_STATE_WAIT  = 3'd2,
        FETCH_STATE_HOLD  = 3'd3,
        FETCH_STATE_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory request/response and execute-side handshake bundle.
// master is the fetch unit, slave is memory plus execute.
interface instruction_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instruction, pc, pcNext, fetch_fault,
        input  instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instruction, pc, pcNext, fetch_fault,
        output instr_ready, redirect_valid, redirect_target
    );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register with sequential/redirect next-PC selection.
// Redirect targets are word-aligned on load.
module fetch_pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pcNext
);

    localparam logic [31:0] STEP  = 32'(INSTRUCTION_BYTES);
    localparam logic [31:0] ALIGN = ~(STEP - 32'd1);

    assign pcNext = pc + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= redirect ? (target & ALIGN) : pcNext;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: BOOT/REQ/WAIT/HOLD sequencer and instruction register.
// INSTRUCTION_FETCH_MISALIGN_TRAP_EN adds a sticky FAULT on misaligned redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);

    fetch_state_e state;
    logic         pc_load;

`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
    logic bad_target;

    assign bad_target = bus.redirect_valid &&
                        (bus.redirect_target[1:0] != 2'b00);
    assign pc_load = (state == FETCH_STATE_HOLD) &&
                     bus.instr_ready && !bad_target;
`else
    assign pc_load = (state == FETCH_STATE_HOLD) && bus.instr_ready;
    assign bus.fetch_fault = 1'b0;
`endif

    fetch_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .redirect (bus.redirect_valid),
        .target   (bus.redirect_target),
        .pc       (bus.pc),
        .pcNext   (bus.pcNext)
    );

    assign bus.imem_req_addr = bus.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= FETCH_STATE_BOOT;
            bus.imem_req_valid <= 1'b0;
            bus.instr_valid    <= 1'b0;
            bus.instruction    <= INSTRUCTION_NOP;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            bus.fetch_fault    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_STATE_BOOT: begin
                    state              <= FETCH_STATE_REQ;
                    bus.imem_req_valid <= 1'b1;
                end
                // a response in the acceptance cycle is ignored
                FETCH_STATE_REQ: begin
                    if (bus.imem_req_ready) begin
                        state              <= FETCH_STATE_WAIT;
                        bus.imem_req_valid <= 1'b0;
                    end
                end
                FETCH_STATE_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state           <= FETCH_STATE_HOLD;
                        bus.instruction <= bus.imem_rsp_data;
                        bus.instr_valid <= 1'b1;
                    end
                end
                FETCH_STATE_HOLD: begin
                    if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
                        if (bad_target) begin
                            state           <= FETCH_STATE_FAULT;
                            bus.fetch_fault <= 1'b1;
                        end else begin
                            state              <= FETCH_STATE_REQ;
                            bus.imem_req_valid <= 1'b1;
                        end
`else
                        state              <= FETCH_STATE_REQ;
                        bus.imem_req_valid <= 1'b1;
`endif
                    end
                end
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
                FETCH_STATE_FAULT: begin
                    state <= FETCH_STATE_FAULT;
                end
`endif
                default: begin
                    state              <= FETCH_STATE_BOOT;
                    bus.imem_req_valid <= 1'b0;
                    bus.instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule
